key_schedule_ctrl: RTL and testbench

Sequencer and storage for the AES-128 key schedule. It accepts one 128-bit cipher key and iterates the expansion step once per clock for 10 rounds. All 11 round keys are held in an internal register bank. Downstream round datapaths (encrypt and decrypt) read the bank through a registered read port, with optional reverse ordering for decryption.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/key_expand_step.sv | 36 +++
 rtl/sub_byte.sv | 53 +++++
 rtl/key_schedule_ctrl.sv | 133 +++++++++++++
 tb/tb_key_schedule_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, FSM encoding, round constants.
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int IDX_W      = 4;

  // Index of the last round key held in the bank.
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd10;

  // Controller states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Round constant for expansion rounds 1..10; any other index yields 0.
  function automatic logic [7:0] rcon_of(input logic [IDX_W-1:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-expansion round: derives round key r from round key r-1.
module key_expand_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prevKey,
  input  logic [7:0]       rconByte,
  output logic [KEY_W-1:0] nextKey
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prevKey[127:96];
  assign w1 = prevKey[95:64];
  assign w2 = prevKey[63:32];
  assign w3 = prevKey[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  subByte u_sub (
    .din  (rot_w3),
    .dout (sub_w3)
  );

  assign t  = sub_w3 ^ {rconByte, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/sub_byte.sv
// 32-bit AES S-box (SubWord): four parallel byte substitutions.
// Each byte is mapped through its GF(2^8) multiplicative inverse
// (x^254, with 0 -> 0) followed by the AES affine transform.
module subByte (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = product of x^(2^k) for k = 1..7, which is the inverse for x != 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution of the whole word.
  always_comb begin
    dout = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      dout[i*8 +: 8] = sbox(din[i*8 +: 8]);
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer with an 11-entry round-key bank and a
// registered read port (optionally reversed for decryption).
// Optional feature macro: KEY_SCHED_ZEROIZE_EN adds a synchronous zeroize input
// that wipes the bank and forces the controller back to IDLE.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic [KEY_W-1:0]   keyIn,
  output logic               busy,
  output logic               done,
  output logic               keyValid,
  input  logic [IDX_W-1:0]   rdAddr,
  input  logic               rdRev,
  output logic [KEY_W-1:0]   rdKey
);

  logic [1:0]       state;
  logic [IDX_W-1:0] round;
  logic [KEY_W-1:0] bank [0:NUM_ROUNDS];

  logic [IDX_W-1:0] prev_idx;
  logic [KEY_W-1:0] prev_key;
  logic [7:0]       rcon_byte;
  logic [KEY_W-1:0] next_key;

  logic             rd_in_range;
  logic [IDX_W-1:0] eff_idx;
  logic [KEY_W-1:0] rd_next;

  // Select the previous round key and round constant feeding the shared step.
  always_comb begin
    if (round == 4'd0) begin
      prev_idx = 4'd0;
    end else begin
      prev_idx = round - 4'd1;
    end
    prev_key  = bank[prev_idx];
    rcon_byte = rcon_of(round);
  end

  key_expand_step u_step (
    .prevKey  (prev_key),
    .rconByte (rcon_byte),
    .nextKey  (next_key)
  );

  // Resolve the read index; out-of-range or unready reads return zero.
  always_comb begin
    rd_in_range = (rdAddr <= LAST_IDX);
    if (!rd_in_range) begin
      eff_idx = 4'd0;
    end else if (rdRev) begin
      eff_idx = LAST_IDX - rdAddr;
    end else begin
      eff_idx = rdAddr;
    end
    if (keyValid && rd_in_range) begin
      rd_next = bank[eff_idx];
    end else begin
      rd_next = '0;
    end
  end

  // Sequencer, round-key bank and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      round    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      keyValid <= 1'b0;
      rdKey    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        bank[i] <= '0;
      end
    end
`ifdef KEY_SCHED_ZEROIZE_EN
    else if (zeroize) begin
      state    <= ST_IDLE;
      round    <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      keyValid <= 1'b0;
      rdKey    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        bank[i] <= '0;
      end
    end
`endif
    else begin
      done  <= 1'b0;
      rdKey <= rd_next;
      case (state)
        ST_IDLE, ST_READY: begin
          if (start) begin
            bank[0]  <= keyIn;
            round    <= 4'd1;
            busy     <= 1'b1;
            keyValid <= 1'b0;
            state    <= ST_EXPAND;
          end else begin
            state <= state;
          end
        end
        ST_EXPAND: begin
          bank[round] <= next_key;
          if (round == LAST_IDX) begin
            round    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b1;
            keyValid <= 1'b1;
            state    <= ST_READY;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          round    <= 4'd0;
          busy     <= 1'b0;
          keyValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: word-level FIPS-197 reference
// model, per-cycle output comparison, plus literal known-answer checks.
module tb_key_schedule_ctrl;

  typedef logic [10:0][127:0] sched_t;

  logic         clk;
  logic         reset;
  logic         start;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif
  logic [127:0] keyIn;
  logic         busy;
  logic         done;
  logic         keyValid;
  logic [3:0]   rdAddr;
  logic         rdRev;
  logic [127:0] rdKey;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_schedule_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .keyIn    (keyIn),
    .busy     (busy),
    .done     (done),
    .keyValid (keyValid),
    .rdAddr   (rdAddr),
    .rdRev    (rdRev),
    .rdKey    (rdKey)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Inverse found by exhaustive search, then the bitwise affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
             inv[(i + 7) % 8] ^ c[i];
    end
    return s;
  endfunction

  // Classic 44-word FIPS-197 expansion, rcon generated by repeated doubling.
  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
               sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] rd_model(input logic [3:0] a, input logic r,
                                            input logic v, input sched_t s);
    if (!v || a > 4'd10) return '0;
    return r ? s[10 - int'(a)] : s[a];
  endfunction

  // ---------------- behavioural model ----------------
  logic         m_busy, m_done, m_valid;
  logic [127:0] m_rd;
  int           m_left;
  sched_t       m_sched, m_pending;

  // Model: a start launches a 10-edge countdown; the whole schedule appears at the end.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_rd <= '0;
      m_left <= 0; m_sched <= '0; m_pending <= '0;
    end
`ifdef KEY_SCHED_ZEROIZE_EN
    else if (zeroize) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_rd <= '0;
      m_left <= 0; m_sched <= '0;
    end
`endif
    else begin
      m_rd   <= rd_model(rdAddr, rdRev, m_valid, m_sched);
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_valid <= 1'b1; m_sched <= m_pending;
        end
      end else if (start) begin
        m_pending <= expand(keyIn);
        m_left    <= 10;
        m_busy    <= 1'b1;
        m_valid   <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("busy", {127'd0, busy}, {127'd0, m_busy});
    check("done", {127'd0, done}, {127'd0, m_done});
    check("keyValid", {127'd0, keyValid}, {127'd0, m_valid});
    check("rdKey", rdKey, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_expand(input logic [127:0] key, input bit mid_start, output int edges);
    @(negedge clk);
    start = 1'b1; keyIn = key;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      start  = (mid_start && edges == 5) ? 1'b1 : 1'b0;
      keyIn  = mid_start ? '1 : {$urandom, $urandom, $urandom, $urandom};
      rdAddr = 4'($urandom_range(0, 15));
      rdRev  = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic r,
                          input logic [127:0] exp);
    @(negedge clk);
    rdAddr = a; rdRev = r;
    @(negedge clk);
    check(name, rdKey, exp);
  endtask

  task automatic idle_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rdAddr = 4'($urandom_range(0, 15));
      rdRev  = 1'($urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int     edges;
    int     done_seen;
    sched_t ref_s;

    reset = 1'b0; start = 1'b0; keyIn = '0; rdAddr = 4'd0; rdRev = 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif

    // Pin the reference model to published vectors.
    ref_s = expand(FIPS_KEY);
    check("model_fips_r0", ref_s[0], FIPS_KEY);
    check("model_fips_r1", ref_s[1], FIPS_R1);
    check("model_fips_r10", ref_s[10], FIPS_R10);
    ref_s = expand(SEQ_KEY);
    check("model_seq_r10", ref_s[10], SEQ_R10);

    repeat (2) @(negedge clk);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_valid", {127'd0, keyValid}, 128'd0);
    check("reset_rdkey", rdKey, 128'd0);
    reset = 1'b1;
    read_chk("idle_read", 4'd0, 1'b0, 128'd0);

    // FIPS-197 vector and reverse reads.
    run_expand(FIPS_KEY, 1'b0, edges);
    check("fips_done_latency", 128'(edges), 128'd11);
    read_chk("fips_r1", 4'd1, 1'b0, FIPS_R1);
    read_chk("fips_r10", 4'd10, 1'b0, FIPS_R10);
    read_chk("fips_r0", 4'd0, 1'b0, FIPS_KEY);
    read_chk("rev_0", 4'd0, 1'b1, FIPS_R10);
    read_chk("rev_9", 4'd9, 1'b1, FIPS_R1);
    read_chk("rev_12", 4'd12, 1'b1, 128'd0);
    read_chk("fwd_11", 4'd11, 1'b0, 128'd0);
    read_chk("fwd_15", 4'd15, 1'b0, 128'd0);

    // Start while busy is ignored (restart from READY with the same key).
    run_expand(FIPS_KEY, 1'b1, edges);
    check("busy_start_latency", 128'(edges), 128'd11);
    read_chk("busy_start_r10", 4'd10, 1'b0, FIPS_R10);
    read_chk("busy_start_r1", 4'd1, 1'b0, FIPS_R1);

    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    start = 1'b1; keyIn = SEQ_KEY;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_valid", {127'd0, keyValid}, 128'd0);
    check("midrst_rdkey", rdKey, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", 128'(done_seen), 128'd0);
    read_chk("midrst_r3", 4'd3, 1'b0, 128'd0);

    // Expansion from IDLE, then restart from READY with the sequential key.
    run_expand(FIPS_KEY, 1'b0, edges);
    check("idle_start_latency", 128'(edges), 128'd11);
    @(negedge clk);
    start = 1'b1; keyIn = SEQ_KEY;
    @(negedge clk);
    start = 1'b0;
    check("restart_valid_low", {127'd0, keyValid}, 128'd0);
    repeat (11) @(negedge clk);
    read_chk("restart_r10", 4'd10, 1'b0, SEQ_R10);
    read_chk("restart_r0", 4'd0, 1'b0, SEQ_KEY);

    // Randomised keys, random restarts and random reads against the model.
    for (int it = 0; it < 8; it++) begin
      run_expand({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), edges);
      check("rand_latency", 128'(edges), 128'd11);
      idle_random(int'($urandom_range(3, 25)));
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    // Zeroize in READY wipes everything until a fresh expansion completes.
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check("zeroize_valid", {127'd0, keyValid}, 128'd0);
    for (int a = 0; a < 11; a++) read_chk("zeroize_read", 4'(a), 1'b0, 128'd0);
    run_expand(FIPS_KEY, 1'b0, edges);
    check("post_zeroize_latency", 128'(edges), 128'd11);
    read_chk("post_zeroize_r1", 4'd1, 1'b0, FIPS_R1);
`endif

    idle_random(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
